seq_scan_arbiter: RTL and testbench
===================================

# seq_scan_arbiter

Shares one serial sequence-detector instance between two requesters. Each job is a parallel WIDTH-bit word that the block streams, MSB first, into the detector one bit per step. The block counts how many steps leave the detector output high and returns that count to the requester. It sits between the switch/register front end and the detector, drives the detector's input bit, step enable and clear, and grants requesters in round-robin order.

## Interface
- WIDTH, 8, bits per job (≥2)
- CW, $clog2(WIDTH+1), width of hit_count
- clock  in  1  system clock, all logic on posedge
- resetn  in  1  reset, synchronous, active-low
- req  in  2  level request per requester; must be held until its done pulse
- data0  in  WIDTH  job word for requester 0, sampled only on grant
- data1  in  WIDTH  job word for requester 1, sampled only on grant
- det_hit  in  1  detector output (high in detector's "match" states)
- grant  out  2  one-hot owner of the current job; 0 when idle
- busy  out  1  high from CLEAR through DONE
- det_w  out  1  serial bit to detector
- det_step  out  1  one-cycle clock enable to detector register
- det_clear  out  1  one-cycle synchronous clear to detector (returns it to its start state)
- done  out  2  one-cycle pulse on the granted requester's bit at job end
- hit_count  out  CW  hits for the last completed job; valid from done, held until the next CLEAR

## Operation
- Registers: state, sreg[WIDTH-1:0], bitcnt, hits[CW-1:0], grant, last (last served requester).
- IDLE: outputs low. If req≠0, pick the winner. When both requesters are asserting, the winner is the one ≠ last; otherwise the single requester wins. Load sreg from the winner's data, set grant one-hot, go to CLEAR.
- CLEAR: det_clear=1; bitcnt←0, hits←0, hit_count←0; go to SHIFT.
- SHIFT: det_w=sreg[WIDTH-1], det_step=1; go to SAMPLE.
- SAMPLE: det_w held, det_step=0. If det_hit, hits←hits+1. Then sreg←sreg<<1 and bitcnt←bitcnt+1. If bitcnt==WIDTH-1, go to DONE; otherwise go to SHIFT.
- DONE: done[grant index]=1, hit_count←hits, last←grant index; go to IDLE with grant←0.
- hits never exceeds WIDTH, so no saturation logic.
- req is ignored outside IDLE. Changes to data during a job have no effect.
- A requester that keeps req high after done is re-granted only if the other requester is idle.
- Illegal state encodings return to IDLE.

## Timing
- Reset (resetn=0 at a posedge): state=IDLE, grant=0, busy=0, det_w=0, det_step=0, det_clear=0, done=0, hit_count=0, hits=0, last=1 (so requester 0 wins the first tie).
- Reset takes precedence over every transition. Reset mid-job aborts it: no done pulse, hit_count is cleared.
- Job latency, with req sampled in IDLE at cycle t:
  - CLEAR at t+1
  - SHIFT/SAMPLE pairs at t+2 … t+2·WIDTH+1
  - DONE at t+2·WIDTH+2
  - back in IDLE at t+2·WIDTH+3
  - WIDTH=8: done at t+18, with 19 cycles per job including IDLE.
- The detector updates on the edge ending SHIFT, so det_hit is read in SAMPLE, one cycle after its step.
- Exactly one det_step per bit and exactly one det_clear per job. det_clear and det_step are never high together.
- A req rising during DONE is served on the next IDLE cycle.

## Test plan
- Reset: hold resetn=0 for 2 cycles with req=2'b11 → all outputs 0. After release, grant=2'b01 one cycle later, then CLEAR with det_clear=1 for exactly 1 cycle.
- Single job: req=01, data0=8'hFF, with a behavioral detector (ones-run ≥4 or suffix 1101 → hit) → 8 det_step pulses with det_w all 1, done=01 at t+18, hit_count=5.
- Pattern job: req=10, data1=8'b11011101 → det_w sequence 1,1,0,1,1,1,0,1; done=10; hit_count=2.
- Zero job: data0=8'h00 → hit_count=0, done pulses once, busy drops the cycle after DONE.
- Round-robin: req=11 held with data0=FF and data1=DD → grants alternate 01,10,01,10 across four jobs, each job's hit_count correct (5 and 2), with no back-to-back grants to the same requester.
- Abort: resetn=0 during the 4th SAMPLE → no done. Next job after release starts with det_clear and produces a correct count.

Source files
------------

// File: rtl/seq_scan_arbiter_if.sv
// seq_scan_arbiter_if: requester and detector signals shared by the arbiter and its environment.
interface seq_scan_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
);
   logic [1:0]       req;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic             det_hit;
   logic [1:0]       grant;
   logic             busy;
   logic             det_w;
   logic             det_step;
   logic             det_clear;
   logic [1:0]       done;
   logic [CW-1:0]    hit_count;
   modport master (
      output req, data0, data1, det_hit,
      input  grant, busy, det_w, det_step, det_clear, done, hit_count
   );
   modport slave (
      input  req, data0, data1, det_hit,
      output grant, busy, det_w, det_step, det_clear, done, hit_count
   );
endinterface

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin sharing of one serial sequence detector between two requesters,
// streaming each job word MSB first and counting detector hits.
module seq_scan_arbiter #(
   parameter int WIDTH = 8
) (
   input logic               clock,
   input logic               resetn,
   seq_scan_arbiter_if.slave sif
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CLEAR  = 3'd1;
   localparam logic [2:0] SHIFT  = 3'd2;
   localparam logic [2:0] SAMPLE = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   logic [2:0]       r_state;
   logic [WIDTH-1:0] r_sreg;
   logic [CW-1:0]    r_bitcnt;
   logic [CW-1:0]    r_hits;
   logic [CW-1:0]    r_hit_count;
   logic [1:0]       r_grant;
   logic             r_last;
   logic             w_win;
   // On a tie the requester not served last wins; last resets to 1 so requester 0 wins first.
   assign w_win = (sif.req == 2'b11) ? ~r_last : sif.req[1];
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_sreg      <= '0;
         r_bitcnt    <= '0;
         r_hits      <= '0;
         r_hit_count <= '0;
         r_grant     <= 2'b00;
         r_last      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: if (|sif.req) begin
               r_sreg  <= w_win ? sif.data1 : sif.data0;
               r_grant <= w_win ? 2'b10 : 2'b01;
               r_state <= CLEAR;
            end
            CLEAR: begin
               r_bitcnt    <= '0;
               r_hits      <= '0;
               r_hit_count <= '0;
               r_state     <= SHIFT;
            end
            SHIFT: r_state <= SAMPLE;
            SAMPLE: begin
               r_hits   <= r_hits + {{(CW-1){1'b0}}, sif.det_hit};
               r_sreg   <= r_sreg << 1;
               r_bitcnt <= r_bitcnt + 1'b1;
               r_state  <= (r_bitcnt == LAST_BIT) ? DONE : SHIFT;
            end
            DONE: begin
               r_hit_count <= r_hits;
               r_last      <= r_grant[1];
               r_grant     <= 2'b00;
               r_state     <= IDLE;
            end
            default: begin
               r_grant <= 2'b00;
               r_state <= IDLE;
            end
         endcase
      end
   end
   assign sif.grant     = r_grant;
   assign sif.busy      = (r_state == CLEAR) || (r_state == SHIFT) || (r_state == SAMPLE) || (r_state == DONE);
   assign sif.det_w     = ((r_state == SHIFT) || (r_state == SAMPLE)) ? r_sreg[WIDTH-1] : 1'b0;
   assign sif.det_step  = (r_state == SHIFT);
   assign sif.det_clear = (r_state == CLEAR);
   assign sif.done      = (r_state == DONE) ? r_grant : 2'b00;
   assign sif.hit_count = r_hit_count;
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// tb_seq_scan_arbiter: directed and random jobs against a word-level hit-count and round-robin model,
// with a behavioural detector (ones-run of 4 or suffix 1101) driving det_hit.
module tb_seq_scan_arbiter;
   localparam int W = 8;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic m_last = 1'b1;
   logic [3:0] hist;
   int   nbits;
   seq_scan_arbiter_if #(.WIDTH(W)) sif();
   seq_scan_arbiter #(.WIDTH(W)) dut (.clock(clock), .resetn(resetn), .sif(sif));
   always #5 clock = ~clock;
   always @(posedge clock) begin
      if (sif.det_clear) begin
         hist  <= 4'h0;
         nbits <= 0;
      end else if (sif.det_step) begin
         hist  <= {hist[2:0], sif.det_w};
         nbits <= nbits + 1;
      end
   end
   assign sif.det_hit = (nbits >= 4) && ((hist == 4'hF) || (hist == 4'hD));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // Hits = number of 4-bit windows (MSB-first stream) equal to 1111 or 1101.
   function automatic int count_hits(input logic [W-1:0] d);
      int h = 0;
      logic [3:0] win;
      for (int i = 3; i < W; i++) begin
         win = {d[W+2-i], d[W+1-i], d[W-i], d[W-1-i]};
         if (win == 4'hF || win == 4'hD) h++;
      end
      return h;
   endfunction
   task automatic outputs_zero(input string tag);
      chk({tag, "_grant"}, 32'(sif.grant), 0);
      chk({tag, "_busy"}, 32'(sif.busy), 0);
      chk({tag, "_det"}, 32'({sif.det_w, sif.det_step, sif.det_clear}), 0);
      chk({tag, "_done"}, 32'(sif.done), 0);
      chk({tag, "_hit_count"}, 32'(sif.hit_count), 0);
   endtask
   task automatic do_job(input logic [1:0] rq, input logic [W-1:0] d0, input logic [W-1:0] d1, input bit abort);
      logic [W-1:0] word, wbits;
      int win, exp_hits, clears, steps, overlap, done_k, extra_done, busy_low;
      win = (rq == 2'b11) ? (m_last ? 0 : 1) : (rq[1] ? 1 : 0);
      word = win ? d1 : d0;
      exp_hits = count_hits(word);
      sif.req = rq;
      sif.data0 = d0;
      sif.data1 = d1;
      wbits = '0;
      clears = 0; steps = 0; overlap = 0; done_k = 0; extra_done = 0; busy_low = 0;
      for (int k = 1; k <= 2 * W + 3; k++) begin
         @(negedge clock);
         if (k == 1) begin
            chk("grant", 32'(sif.grant), win ? 32'd2 : 32'd1);
            sif.data0 = W'($urandom);
            sif.data1 = W'($urandom);
         end
         if (abort && k == 9) begin
            resetn = 1'b0;
            sif.req = 2'b00;
            @(negedge clock);
            outputs_zero("abort");
            resetn = 1'b1;
            m_last = 1'b1;
            return;
         end
         clears += int'(sif.det_clear);
         overlap += int'(sif.det_clear && sif.det_step);
         if (sif.det_step) begin
            steps++;
            wbits = {wbits[W-2:0], sif.det_w};
         end
         if (sif.done != 2'b00) begin
            if (done_k == 0) begin
               done_k = k;
               chk("done_val", 32'(sif.done), win ? 32'd2 : 32'd1);
            end else extra_done++;
         end
         if (k <= 2 * W + 2) busy_low += int'(!sif.busy);
      end
      chk("busy_drop", 32'(sif.busy), 0);
      chk("busy_low", 32'(busy_low), 0);
      chk("clears", 32'(clears), 1);
      chk("clr_step_overlap", 32'(overlap), 0);
      chk("steps", 32'(steps), W);
      chk("det_w_seq", 32'(wbits), 32'(word));
      chk("done_cycle", 32'(done_k), 2 * W + 2);
      chk("extra_done", 32'(extra_done), 0);
      chk("hit_count", 32'(sif.hit_count), 32'(exp_hits));
      m_last = win[0];
   endtask
   task automatic idle_gap(input int n);
      sif.req = 2'b00;
      repeat (n) begin
         @(negedge clock);
         chk("idle_grant", 32'(sif.grant), 0);
         chk("idle_busy", 32'(sif.busy), 0);
      end
   endtask
   initial begin
      logic [1:0] rq;
      sif.req = 2'b11;
      sif.data0 = 8'hFF;
      sif.data1 = 8'hDD;
      repeat (2) @(negedge clock);
      outputs_zero("reset");
      resetn = 1'b1;
      do_job(2'b11, 8'hFF, 8'hDD, 1'b0);
      do_job(2'b01, 8'hFF, 8'h00, 1'b0);
      do_job(2'b10, 8'h00, 8'hDD, 1'b0);
      do_job(2'b01, 8'h00, 8'hFF, 1'b0);
      idle_gap(3);
      repeat (4) do_job(2'b11, 8'hFF, 8'hDD, 1'b0);
      do_job(2'b01, 8'hFF, 8'hDD, 1'b1);
      do_job(2'b10, 8'h0F, 8'hDD, 1'b0);
      for (int j = 0; j < 40; j++) begin
         rq = 2'($urandom_range(1, 3));
         do_job(rq, W'($urandom), W'($urandom), 1'b0);
         if ($urandom_range(0, 5) == 0) idle_gap($urandom_range(1, 3));
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
